gb_fanout_interposer: RTL and testbench
=======================================

// Module: gb_fanout_interposer
// PURPOSE
// - Parametrised ghostbus interposer: takes one host bus, decodes it onto NCH child buses, pipelines
//   strobes out and read data back, and feeds each child a staggered copy of a local demo_sig.
// - Sits between a parent bus node and NCH identical child instances, replacing hand-written
//   fixed two-child interposers.
// PARAMETERS
// - AW      24        host address width
// - DW      32        data width
// - NCH     4         child channel count, 1..16 (non-power-of-2 allowed)
// - CH_AW   8         address bits forwarded to each child
// - BASE    0         host base address of this node; multiple of 2**(CH_AW+CW), CW=max(1,clog2(NCH))
// - DSTEP   1         demo_sig delay step; channel k sees k*DSTEP cycles of delay
// - BADDATA 32'h0     rdata returned for out-of-range reads
// PORTS
// - clk          in   1        single clock, all logic rising edge
// - rst_n        in   1        synchronous, active-low reset
// - host_addr    in   AW       host address, sampled with a strobe
// - host_wdata   in   DW       host write data
// - host_we      in   1        write strobe, one cycle per access
// - host_re      in   1        read strobe, one cycle per access
// - host_rdata   out  DW       read data, valid with host_rvalid
// - host_rvalid  out  1        one-cycle read-return pulse
// - ch_addr      out  CH_AW    registered host_addr[CH_AW-1:0], shared by all channels
// - ch_wdata     out  DW       registered write data, shared
// - ch_we        out  NCH      one-hot registered write strobes
// - ch_re        out  NCH      one-hot registered read strobes
// - ch_rdata     in   NCH*DW   child read data, ch k at [k*DW +: DW]; fixed child latency 1
// - demo_sig     in   1        local status net to distribute
// - ch_demo      out  NCH      ch_demo[k] = demo_sig delayed k*DSTEP cycles
// - err_cnt      out  16       out-of-range/protocol error count
// BEHAVIOUR
// - Reset (rst_n=0 at edge): all outputs 0, read pipeline cleared, delay lines 0, err_cnt 0.
// - Decode: hit when addr[AW-1:CH_AW+CW]==BASE[AW-1:CH_AW+CW] and idx=addr[CH_AW+CW-1:CH_AW] < NCH.
// - Cycle 0 strobe sampled; cycle 1 ch_we/ch_re[idx]=1 for exactly one cycle with ch_addr/ch_wdata.
// - Cycle 2: child drives ch_rdata; interposer registers ch_rdata[idx] (idx carried in pipeline tag).
// - Cycle 3: host_rvalid=1, host_rdata=captured data. Fixed read latency 3; one read per cycle sustained.
// - Out-of-range write: no ch_we, dropped, error counted.
// - Out-of-range read: no ch_re; host_rvalid still at cycle 3 with host_rdata=BADDATA; error counted.
// - host_we & host_re same cycle: protocol error; write proceeds, read dropped (no rvalid), counted.
// - host_rdata holds last value between rvalid pulses; ch_addr/ch_wdata hold last value.
// - Reset mid-read: in-flight reads discarded, no rvalid emitted after reset release.
// - Delay line: ch_demo[0] is combinational pass-through of demo_sig; k>0 registered shift chain.
// CONFIGURATION
// - GB_INTERPOSER_ERRCNT_EN defined: err_cnt increments by 1 per error event, saturates at 16'hFFFF,
//   cleared only by reset.
// - Not defined: counter logic omitted, err_cnt tied to 16'h0; all other behaviour identical.
// STRUCTURE
// - gb_pkg: clog2 function, GB_RD_LATENCY=3, GB_CHILD_LATENCY=1, read-pipeline tag struct/width
//   constants {valid, oor, idx[CW-1:0]}.
// - Sub-module gb_delay_line (param DEPTH, reset 0, DEPTH=0 -> wire); instantiated per channel k
//   with DEPTH=k*DSTEP in a generate loop. Decode, strobe regs, read mux, err counter in top.
// TESTING
// - NCH=4,CH_AW=8,BASE=0: write 0x0205 data 0xA5A5A5A5 -> cycle1 ch_we=4'b0100, ch_addr=0x05.
// - Reads to ch0..ch3 back-to-back, child returns 0x1000+k -> rvalid 4 consecutive cycles,
//   data 0x1000..0x1003 in order, each 3 cycles after its host_re.
// - Read 0x0405 (idx 4 out of range with CW=2? no: addr bit 10 set, above BASE span) -> no ch_re,
//   rvalid at +3 with BADDATA, err_cnt=1 (ERRCNT_EN) / 0 (not defined).
// - NCH=3, read idx 3 -> out of range: BADDATA, no strobe; we&re together -> write only, err_cnt+1.
// - demo_sig pulse 1 cycle, DSTEP=2 -> ch_demo[0..3] pulse at +0,+2,+4,+6 cycles.
// - rst_n low one cycle between host_re and its rvalid -> no rvalid, outputs 0, err_cnt 0.

Source files
------------

// File: rtl/gb_pkg.sv
// rtl/gb_pkg.sv - shared constants, read-pipeline tag type and clog2 helper for the ghostbus interposer
package gb_pkg;

    localparam int GB_RD_LATENCY    = 3;
    localparam int GB_CHILD_LATENCY = 1;
    localparam int GB_IDX_W         = 4;

    // Travels with each read so the return stage knows which child (or BADDATA) to answer with.
    typedef struct packed {
        logic                valid;
        logic                oor;
        logic [GB_IDX_W-1:0] idx;
    } gb_rd_tag_t;

    localparam int GB_TAG_W = $bits(gb_rd_tag_t);

    function automatic int gb_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gb_delay_line.sv
// rtl/gb_delay_line.sv - DEPTH-cycle single-bit delay with reset to 0; DEPTH=0 is a plain wire
module gb_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, i_clk, i_rst_n};
            assign o_q = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0] r_sh;
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_sh <= '0;
                end else begin
                    r_sh[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sh[i] <= r_sh[i-1];
                    end
                end
            end
            assign o_q = r_sh[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/gb_fanout_interposer.sv
// rtl/gb_fanout_interposer.sv - host-to-NCH-children bus decoder with 3-cycle read return and staggered demo_sig
// Optional error counter enabled by defining GB_INTERPOSER_ERRCNT_EN.
module gb_fanout_interposer
    import gb_pkg::*;
#(
    parameter int              AW      = 24,
    parameter int              DW      = 32,
    parameter int              NCH     = 4,
    parameter int              CH_AW   = 8,
    parameter int unsigned     BASE    = 0,
    parameter int              DSTEP   = 1,
    parameter logic [DW-1:0]   BADDATA = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       host_addr,
    input  logic [DW-1:0]       host_wdata,
    input  logic                host_we,
    input  logic                host_re,
    output logic [DW-1:0]       host_rdata,
    output logic                host_rvalid,
    output logic [CH_AW-1:0]    ch_addr,
    output logic [DW-1:0]       ch_wdata,
    output logic [NCH-1:0]      ch_we,
    output logic [NCH-1:0]      ch_re,
    input  logic [NCH*DW-1:0]   ch_rdata,
    input  logic                demo_sig,
    output logic [NCH-1:0]      ch_demo,
    output logic [15:0]         err_cnt
);

    localparam int            CW     = (gb_clog2(NCH) < 1) ? 1 : gb_clog2(NCH);
    localparam int            HI_LSB = CH_AW + CW;
    localparam logic [AW-1:0] BASE_V = AW'(BASE);

    logic [CW-1:0]    w_idx;
    logic             w_hit;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic [NCH-1:0]   w_onehot;
    gb_rd_tag_t       w_tag0;
    logic [DW-1:0]    w_child_rdata;

    gb_rd_tag_t       r_tag1;
    gb_rd_tag_t       r_tag2;
    logic [CH_AW-1:0] r_ch_addr;
    logic [DW-1:0]    r_ch_wdata;
    logic [NCH-1:0]   r_ch_we;
    logic [NCH-1:0]   r_ch_re;
    logic [DW-1:0]    r_host_rdata;
    logic             r_host_rvalid;

    assign w_idx    = host_addr[HI_LSB-1:CH_AW];
    assign w_hit    = (host_addr[AW-1:HI_LSB] == BASE_V[AW-1:HI_LSB]) && (32'(w_idx) < NCH);
    // A simultaneous read is dropped so the write alone reaches the child.
    assign w_wr_ok  = host_we & w_hit;
    assign w_rd_ok  = host_re & ~host_we & w_hit;
    assign w_onehot = NCH'(1) << w_idx;

    always_comb begin
        w_tag0       = '0;
        w_tag0.valid = host_re & ~host_we;
        w_tag0.oor   = ~w_hit;
        w_tag0.idx   = GB_IDX_W'(w_idx);
    end

    always_comb begin
        w_child_rdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_tag2.idx == GB_IDX_W'(k)) w_child_rdata = ch_rdata[k*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag1        <= '0;
            r_tag2        <= '0;
            r_ch_addr     <= '0;
            r_ch_wdata    <= '0;
            r_ch_we       <= '0;
            r_ch_re       <= '0;
            r_host_rdata  <= '0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_ch_we <= w_wr_ok ? w_onehot : '0;
            r_ch_re <= w_rd_ok ? w_onehot : '0;
            if (w_wr_ok | w_rd_ok) r_ch_addr <= host_addr[CH_AW-1:0];
            if (w_wr_ok) r_ch_wdata <= host_wdata;
            // tag2 lines up with the cycle the child drives its read data
            r_tag1        <= w_tag0;
            r_tag2        <= r_tag1;
            r_host_rvalid <= r_tag2.valid;
            if (r_tag2.valid) r_host_rdata <= r_tag2.oor ? BADDATA : w_child_rdata;
        end
    end

    assign ch_addr     = r_ch_addr;
    assign ch_wdata    = r_ch_wdata;
    assign ch_we       = r_ch_we;
    assign ch_re       = r_ch_re;
    assign host_rdata  = r_host_rdata;
    assign host_rvalid = r_host_rvalid;

`ifdef GB_INTERPOSER_ERRCNT_EN
    logic        w_err_evt;
    logic [15:0] r_err_cnt;

    assign w_err_evt = (host_we | host_re) & (~w_hit | (host_we & host_re));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_err_evt && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'h0;
`endif

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_demo
            gb_delay_line #(
                .DEPTH (k * DSTEP)
            ) u_delay (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .i_d     (demo_sig),
                .o_q     (ch_demo[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gb_fanout_interposer.sv
// tb/tb_gb_fanout_interposer.sv - directed and randomized checks of two interposer builds (NCH=4/DSTEP=2, NCH=3/DSTEP=1)
module tb_gb_fanout_interposer;

`ifdef GB_INTERPOSER_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] BAD4 = 32'hDEAD_BEEF;
    localparam logic [31:0] BAD3 = 32'hBAD0_0003;

    logic         clk;
    logic         rst_n;
    logic [23:0]  host_addr;
    logic [31:0]  host_wdata;
    logic         host_we;
    logic         host_re;
    logic         demo_sig;

    logic [31:0]  host_rdata4, host_rdata3;
    logic         host_rvalid4, host_rvalid3;
    logic [7:0]   ch_addr4, ch_addr3;
    logic [31:0]  ch_wdata4, ch_wdata3;
    logic [3:0]   ch_we4, ch_re4, ch_demo4;
    logic [2:0]   ch_we3, ch_re3, ch_demo3;
    logic [127:0] ch_rdata4;
    logic [95:0]  ch_rdata3;
    logic [15:0]  err_cnt4, err_cnt3;

    int checks;
    int failures;
    int e_err0;
    int e_err1;

    logic [31:0] e_rd [int];
    logic [3:0]  e_we [int];
    logic [3:0]  e_re [int];

    gb_fanout_interposer #(
        .AW(24), .DW(32), .NCH(4), .CH_AW(8), .BASE(0), .DSTEP(2), .BADDATA(BAD4)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_we(host_we), .host_re(host_re), .host_rdata(host_rdata4), .host_rvalid(host_rvalid4),
        .ch_addr(ch_addr4), .ch_wdata(ch_wdata4), .ch_we(ch_we4), .ch_re(ch_re4),
        .ch_rdata(ch_rdata4), .demo_sig(demo_sig), .ch_demo(ch_demo4), .err_cnt(err_cnt4)
    );

    gb_fanout_interposer #(
        .AW(24), .DW(32), .NCH(3), .CH_AW(8), .BASE(0), .DSTEP(1), .BADDATA(BAD3)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_we(host_we), .host_re(host_re), .host_rdata(host_rdata3), .host_rvalid(host_rvalid3),
        .ch_addr(ch_addr3), .ch_wdata(ch_wdata3), .ch_we(ch_we3), .ch_re(ch_re3),
        .ch_rdata(ch_rdata3), .demo_sig(demo_sig), .ch_demo(ch_demo3), .err_cnt(err_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Child models: answer one cycle after their read strobe with 0x1000 + k + (addr << 16).
    initial begin
        ch_rdata4 = '0;
        ch_rdata3 = '0;
    end
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (ch_re4[k]) ch_rdata4[k*32 +: 32] <= 32'h1000 + 32'(k) + {8'h0, ch_addr4, 16'h0};
        for (int k = 0; k < 3; k++)
            if (ch_re3[k]) ch_rdata3[k*32 +: 32] <= 32'h1000 + 32'(k) + {8'h0, ch_addr3, 16'h0};
    end

    task automatic drive_idle();
        host_we    = 1'b0;
        host_re    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        demo_sig = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        checks++;
        if ({host_rvalid4, host_rdata4, ch_we4, ch_re4, ch_addr4, ch_wdata4, err_cnt4, ch_demo4} !== '0) begin
            failures++;
            $display("FAIL reset_dut4 got=%b/%h/%b/%b/%h/%h/%h exp=all zero", host_rvalid4, host_rdata4,
                     ch_we4, ch_re4, ch_addr4, ch_wdata4, err_cnt4);
        end
        checks++;
        if ({host_rvalid3, host_rdata3, ch_we3, ch_re3, ch_addr3, ch_wdata3, err_cnt3, ch_demo3} !== '0) begin
            failures++;
            $display("FAIL reset_dut3 got=%b/%h/%b/%b/%h/%h/%h exp=all zero", host_rvalid3, host_rdata3,
                     ch_we3, ch_re3, ch_addr3, ch_wdata3, err_cnt3);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({host_rvalid4, ch_we4, ch_re4, host_rvalid3, ch_we3, ch_re3} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b%b%b%b%b%b exp=0", host_rvalid4, ch_we4, ch_re4,
                     host_rvalid3, ch_we3, ch_re3);
        end
    endtask

    task automatic test_write_decode();
        @(negedge clk);
        host_we = 1'b1; host_addr = 24'h000205; host_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        drive_idle();
        checks++;
        if ({ch_we4, ch_re4, ch_addr4, ch_wdata4} !== {4'b0100, 4'b0000, 8'h05, 32'hA5A5_A5A5}) begin
            failures++;
            $display("FAIL write_decode4 got=%b %b %h %h exp=0100 0000 05 a5a5a5a5", ch_we4, ch_re4, ch_addr4, ch_wdata4);
        end
        checks++;
        if ({ch_we3, ch_addr3, ch_wdata3} !== {3'b100, 8'h05, 32'hA5A5_A5A5}) begin
            failures++;
            $display("FAIL write_decode3 got=%b %h %h exp=100 05 a5a5a5a5", ch_we3, ch_addr3, ch_wdata3);
        end
        @(negedge clk);
        checks++;
        if ({ch_we4, ch_we3, ch_addr4, ch_wdata4} !== {7'b0, 8'h05, 32'hA5A5_A5A5}) begin
            failures++;
            $display("FAIL write_one_cycle got=%b %b %h %h exp=0000 000 05 a5a5a5a5", ch_we4, ch_we3, ch_addr4, ch_wdata4);
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_rv;
        logic [3:0]  exp_re4;
        logic [31:0] exp_rd4, exp_rd3;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j < 4) begin
                host_re = 1'b1; host_addr = 24'(j * 256);
            end else begin
                drive_idle();
            end
            exp_re4 = (j >= 1 && j <= 4) ? 4'(1 << (j - 1)) : 4'b0;
            checks++;
            if ({ch_re4, ch_re3} !== {exp_re4, (j == 4) ? 3'b000 : exp_re4[2:0]}) begin
                failures++;
                $display("FAIL b2b_strobe j=%0d got=%b %b exp=%b", j, ch_re4, ch_re3, exp_re4);
            end
            exp_rv  = (j >= 3 && j <= 6);
            exp_rd4 = (j >= 3) ? 32'h1000 + 32'((j > 6 ? 6 : j) - 3) : 32'h0;
            exp_rd3 = (j >= 6) ? BAD3 : exp_rd4;
            checks++;
            if ({host_rvalid4, host_rvalid3} !== {exp_rv, exp_rv} ||
                (j >= 3 && {host_rdata4, host_rdata3} !== {exp_rd4, exp_rd3})) begin
                failures++;
                $display("FAIL b2b_read j=%0d got=%b %h %b %h exp=%b %h %h", j, host_rvalid4, host_rdata4,
                         host_rvalid3, host_rdata3, exp_rv, exp_rd4, exp_rd3);
            end
        end
        e_err1++;
    endtask

    task automatic test_out_of_range();
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            drive_idle();
            if (j == 0) begin host_re = 1'b1; host_addr = 24'h000405; end
            if (j == 4) begin host_we = 1'b1; host_addr = 24'h000405; host_wdata = 32'h55; end
            if (j == 1) begin
                checks++;
                if ({ch_re4, ch_re3} !== 7'b0) begin
                    failures++;
                    $display("FAIL oor_no_re got=%b %b exp=0", ch_re4, ch_re3);
                end
            end
            if (j == 3) begin
                checks++;
                if ({host_rvalid4, host_rdata4, host_rvalid3, host_rdata3} !== {1'b1, BAD4, 1'b1, BAD3}) begin
                    failures++;
                    $display("FAIL oor_read got=%b %h %b %h exp=1 %h 1 %h", host_rvalid4, host_rdata4,
                             host_rvalid3, host_rdata3, BAD4, BAD3);
                end
            end
            if (j == 4) begin
                checks++;
                if ({host_rvalid4, host_rvalid3, host_rdata4} !== {2'b00, BAD4}) begin
                    failures++;
                    $display("FAIL oor_rvalid_pulse got=%b %b %h exp=0 0 %h", host_rvalid4, host_rvalid3, host_rdata4, BAD4);
                end
            end
            if (j == 5) begin
                e_err0 += 2;
                e_err1 += 2;
                checks++;
                if ({ch_we4, ch_we3, ch_wdata4} !== {7'b0, 32'hA5A5_A5A5}) begin
                    failures++;
                    $display("FAIL oor_write got=%b %b %h exp=0 0 a5a5a5a5", ch_we4, ch_we3, ch_wdata4);
                end
                checks++;
                if ({err_cnt4, err_cnt3} !== (ERR_EN ? {16'(e_err0), 16'(e_err1)} : 32'h0)) begin
                    failures++;
                    $display("FAIL oor_err_cnt got=%0d %0d exp=%0d %0d", err_cnt4, err_cnt3,
                             ERR_EN ? e_err0 : 0, ERR_EN ? e_err1 : 0);
                end
            end
        end
    endtask

    task automatic test_protocol_err();
        @(negedge clk);
        host_we = 1'b1; host_re = 1'b1; host_addr = 24'h000106; host_wdata = 32'h1234_5678;
        e_err0++;
        e_err1++;
        for (int j = 1; j < 6; j++) begin
            @(negedge clk);
            drive_idle();
            if (j == 1) begin
                checks++;
                if ({ch_we4, ch_re4, ch_re3, ch_addr4, ch_wdata4} !== {4'b0010, 4'b0, 3'b0, 8'h06, 32'h1234_5678}) begin
                    failures++;
                    $display("FAIL we_re_write got=%b %b %b %h %h exp=0010 0000 000 06 12345678",
                             ch_we4, ch_re4, ch_re3, ch_addr4, ch_wdata4);
                end
                checks++;
                if ({err_cnt4, err_cnt3} !== (ERR_EN ? {16'(e_err0), 16'(e_err1)} : 32'h0)) begin
                    failures++;
                    $display("FAIL we_re_err_cnt got=%0d %0d exp=%0d %0d", err_cnt4, err_cnt3,
                             ERR_EN ? e_err0 : 0, ERR_EN ? e_err1 : 0);
                end
            end
            checks++;
            if ({host_rvalid4, host_rvalid3} !== 2'b00) begin
                failures++;
                $display("FAIL we_re_no_rvalid j=%0d got=%b %b exp=0 0", j, host_rvalid4, host_rvalid3);
            end
        end
    endtask

    task automatic test_demo();
        logic [3:0] exp4;
        logic [2:0] exp3;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            demo_sig = (j == 0);
            #1;
            for (int k = 0; k < 4; k++) exp4[k] = (j == 2 * k);
            for (int k = 0; k < 3; k++) exp3[k] = (j == k);
            checks++;
            if ({ch_demo4, ch_demo3} !== {exp4, exp3}) begin
                failures++;
                $display("FAIL demo_delay j=%0d got=%b %b exp=%b %b", j, ch_demo4, ch_demo3, exp4, exp3);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        host_re = 1'b1; host_addr = 24'h000100;
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        e_err0 = 0;
        e_err1 = 0;
        checks++;
        if ({host_rdata4, host_rdata3, err_cnt4, err_cnt3, ch_addr4, ch_wdata4, ch_re4, ch_re3} !== '0) begin
            failures++;
            $display("FAIL mid_reset_zero got=%h %h %0d %0d %h %h %b %b exp=all zero", host_rdata4, host_rdata3,
                     err_cnt4, err_cnt3, ch_addr4, ch_wdata4, ch_re4, ch_re3);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if ({host_rvalid4, host_rvalid3} !== 2'b00) begin
                failures++;
                $display("FAIL mid_reset_no_rvalid j=%0d got=%b %b exp=0 0", j, host_rvalid4, host_rvalid3);
            end
        end
    endtask

    task automatic test_random();
        localparam int N = 400;
        logic [31:0] m_rdata [2];
        logic [7:0]  m_addr  [2];
        logic [31:0] m_wdata [2];
        int          m_err   [2];
        logic        rv;
        logic [31:0] rd, wd, exp_rd;
        logic [3:0]  we_o, re_o, exp_we, exp_re;
        logic [7:0]  ad;
        logic [15:0] ec;
        logic        exp_rv, we, re, hit;
        int          a, op, cls, nch, idx, key;
        e_rd.delete();
        e_we.delete();
        e_re.delete();
        for (int d = 0; d < 2; d++) begin
            m_rdata[d] = '0; m_addr[d] = '0; m_wdata[d] = '0; m_err[d] = 0;
        end
        for (int t = 0; t < N + 4; t++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    rv = host_rvalid4; rd = host_rdata4; we_o = ch_we4; re_o = ch_re4;
                    ad = ch_addr4; wd = ch_wdata4; ec = err_cnt4;
                end else begin
                    rv = host_rvalid3; rd = host_rdata3; we_o = {1'b0, ch_we3}; re_o = {1'b0, ch_re3};
                    ad = ch_addr3; wd = ch_wdata3; ec = err_cnt3;
                end
                key    = t * 2 + d;
                exp_rv = e_rd.exists(key);
                if (exp_rv) m_rdata[d] = e_rd[key];
                exp_rd = m_rdata[d];
                exp_we = e_we.exists(key) ? e_we[key] : 4'b0;
                exp_re = e_re.exists(key) ? e_re[key] : 4'b0;
                checks++;
                if ({rv, rd} !== {exp_rv, exp_rd}) begin
                    failures++;
                    $display("FAIL rand_read t=%0d dut=%0d got=%b %h exp=%b %h", t, d, rv, rd, exp_rv, exp_rd);
                end
                checks++;
                if ({we_o, re_o, ad, wd} !== {exp_we, exp_re, m_addr[d], m_wdata[d]}) begin
                    failures++;
                    $display("FAIL rand_strobe t=%0d dut=%0d got=%b %b %h %h exp=%b %b %h %h", t, d,
                             we_o, re_o, ad, wd, exp_we, exp_re, m_addr[d], m_wdata[d]);
                end
                checks++;
                if (ec !== (ERR_EN ? 16'(m_err[d]) : 16'h0)) begin
                    failures++;
                    $display("FAIL rand_err_cnt t=%0d dut=%0d got=%0d exp=%0d", t, d, ec, ERR_EN ? m_err[d] : 0);
                end
            end
            drive_idle();
            if (t < N) begin
                op  = int'($urandom_range(0, 9));
                cls = int'($urandom_range(0, 9));
                if (cls < 6)      a = int'($urandom_range(0, 3)) * 256 + int'($urandom_range(0, 255));
                else if (cls < 8) a = int'($urandom_range(1024, 24'hFFFFFF));
                else              a = 3 * 256 + int'($urandom_range(0, 255));
                we = (op >= 6);
                re = (op >= 3 && op <= 5) || (op == 9);
                host_we = we; host_re = re; host_addr = 24'(a); host_wdata = $urandom;
                for (int d = 0; d < 2; d++) begin
                    nch = (d == 0) ? 4 : 3;
                    idx = a / 256;
                    hit = (a < 1024) && (idx < nch);
                    if (we && hit) begin
                        e_we[(t + 1) * 2 + d] = 4'(1 << idx);
                        m_addr[d]  = 8'(a % 256);
                        m_wdata[d] = host_wdata;
                    end
                    if (re && !we) begin
                        if (hit) begin
                            e_re[(t + 1) * 2 + d] = 4'(1 << idx);
                            m_addr[d] = 8'(a % 256);
                        end
                        e_rd[(t + 3) * 2 + d] = hit ? 32'h1000 + 32'(idx) + 32'((a % 256) << 16)
                                                    : ((d == 0) ? BAD4 : BAD3);
                    end
                    if ((we || re) && (!hit || (we && re)) && m_err[d] < 65535) m_err[d]++;
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        e_err0   = 0;
        e_err1   = 0;
        test_reset();
        test_write_decode();
        test_back_to_back();
        test_out_of_range();
        test_protocol_err();
        test_demo();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
